stack_arbiter: RTL
==================

Name: stack_arbiter

Overview:
- Two-port controller that shares one hardware stack (push/peek/full/not_empty interface, c=1 push, c=0 pop, en qualifies) between two requesters, e.g. the control unit (CALL/RET) and the interrupt unit (context save/restore).
- Arbitrates round-robin and sequences the stack's en/c lines, including the peek-refresh cycle the stack needs before a pop.
- Returns popped data, and reports overflow/underflow as an error instead of silently dropping the operation.

Parameters:
- WIDTH, 8, data width; must equal the stack's width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- clr  input  1  synchronous active-high reset, shared with the stack.
- req0  input  1  requester 0 request; held until ack0.
- op0  input  1  requester 0 operation: 1 = push, 0 = pop.
- wdata0  input  WIDTH  requester 0 push data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- req1, op1, wdata1, ack1: same as above for requester 1.
- rdata  output  WIDTH  popped value; valid while an ack is high for a pop.
- err  output  1  high with ack when a push hit full or a pop hit empty.
- busy  output  1  high in any state other than IDLE.
- stk_en  output  1  stack enable.
- stk_c  output  1  stack control: 1 = push, 0 = pop.
- stk_push  output  WIDTH  data to the stack push input.
- stk_peek  input  WIDTH  stack top-of-stack value.
- stk_full  input  1  stack full flag.
- stk_not_empty  input  1  stack non-empty flag.

Behaviour:
- Stack contract relied on:
  - en=1, c=1 with full=0 pushes at the edge.
  - en=1, c=0 with not_empty=1 pops at the edge.
  - peek reflects the current top only after an edge with en=0.
- Reset (clr=1 at posedge): state=IDLE, ack0=ack1=0, err=0, rdata=0, stk_en=0, stk_c=0, stk_push=0, last_grant=1 (so requester 0 wins the first tie).
  - Reset mid-operation abandons the operation with no ack. The stack is cleared by the same clr.
- All outputs are registered Moore outputs derived from state and latched fields.
- FSM states: IDLE, PUSH, SYNC, POP, DONE.
- IDLE:
  - stk_en=0.
  - If exactly one req is high, grant it. If both are high, grant the one not equal to last_grant, then set last_grant to the granted index.
  - Latch op, wdata and the granted index.
  - Next state:
    - push with stk_full=0 -> PUSH.
    - pop with stk_not_empty=1 -> SYNC.
    - push with stk_full=1, or pop with stk_not_empty=0 -> DONE with err latched to 1 and rdata=0; no stack operation.
  - With no request, stay in IDLE.
- PUSH: stk_en=1, stk_c=1, stk_push=latched wdata. Next state DONE.
- SYNC: stk_en=0, so the stack refreshes peek at this edge. Next state POP.
- POP: stk_en=1, stk_c=0. At the exiting edge, rdata<=stk_peek. Next state DONE.
- DONE:
  - stk_en=0.
  - ack of the granted requester is 1 for exactly this cycle; err holds the latched value.
  - Next state IDLE; err clears on leaving DONE.
  - rdata holds until the next pop completes or clr.
- Latency from the edge that samples req to the ack cycle: push 2 cycles, pop 3 cycles, error 1 cycle.
  - Back-to-back throughput is limited by the one IDLE cycle per operation.
- Requesters must hold req, op and wdata stable until their ack, and drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Changes to req or op while not in IDLE are ignored. stk_full and stk_not_empty are sampled only in IDLE.
- Both requesters continuously requesting alternate strictly: 0,1,0,1…
- busy=0 only in IDLE.

Test Plan:
- Reset, then req0 push 0x11 -> PUSH state drives stk_en=1, stk_c=1, stk_push=0x11; ack0 pulses 2 cycles after sampling with err=0; stk_not_empty=1.
- Push 0x11 then 0x22 from req0, then req1 pop -> ack1 3 cycles after sampling with rdata=0x22, err=0; a second req1 pop returns 0x11.
- Pop on an empty stack from req1 -> ack1 1 cycle after sampling, err=1, rdata=0, stk_en never asserted.
- Fill the stack (depth parameter 1: 1 entry), then push 0x33 -> ack with err=1, no stk_en pulse; a following pop returns the earlier value, not 0x33.
- req0 and req1 both held high, pushing 0xA0 and 0xB0 -> grants order 0, then 1, each ack a single-cycle pulse; subsequent pops return 0xB0 then 0xA0.
- Assert clr during the POP state -> no ack, all outputs at their reset values the next cycle, busy=0; a new push after reset completes normally.

Source files
------------

// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a single hardware stack.
// Sequences push, peek-refresh and pop cycles and flags full/empty misuse.
module stack_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req0,
   input  logic             op0,
   input  logic [WIDTH-1:0] wdata0,
   output logic             ack0,
   input  logic             req1,
   input  logic             op1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata,
   output logic             err,
   output logic             busy,
   output logic             stk_en,
   output logic             stk_c,
   output logic [WIDTH-1:0] stk_push,
   input  logic [WIDTH-1:0] stk_peek,
   input  logic             stk_full,
   input  logic             stk_not_empty
);

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      SYNC,
      POP,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             busy_q, busy_d;
   logic             en_q, en_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] push_q, push_d;
   logic             sel;

   // Next state, latched fields and the Moore outputs of the next state
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      sel     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               sel     = (req0 && req1) ? ~last_q : req1;
               gnt_d   = sel;
               last_d  = sel;
               op_d    = sel ? op1 : op0;
               wdata_d = sel ? wdata1 : wdata0;
               if (op_d && !stk_full) begin
                  state_d = PUSH;
               end else if (!op_d && stk_not_empty) begin
                  state_d = SYNC;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         PUSH: state_d = DONE;
         SYNC: state_d = POP;
         POP: begin
            state_d = DONE;
            rdata_d = stk_peek;
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      ack0_d = (state_d == DONE) && !gnt_d;
      ack1_d = (state_d == DONE) && gnt_d;
      busy_d = (state_d != IDLE);
      en_d   = (state_d == PUSH) || (state_d == POP);
      c_d    = (state_d == PUSH);
      push_d = (state_d == PUSH) ? wdata_d : '0;
   end

   // State, latched request fields and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         c_q     <= 1'b0;
         push_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
         c_q     <= c_d;
         push_q  <= push_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata    = rdata_q;
   assign err      = err_q;
   assign busy     = busy_q;
   assign stk_en   = en_q;
   assign stk_c    = c_q;
   assign stk_push = push_q;

endmodule
